// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the mesh router output arbiter.
//   - flit type encodings (top FLIT_TYPE_W bits of a routed flit)
//   - arbiter FSM state enum
//   - NUM_PORTS and small flit-type helper functions
package noc_pkg;

   localparam int NUM_PORTS   = 4;
   // The type field occupies the FLIT_TYPE_W most significant bits of a flit.
   localparam int FLIT_TYPE_W = 2;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Flit may open a new packet (and therefore win IDLE arbitration).
   function automatic logic starts_packet(input flit_type_e t);
      return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
   endfunction

   // Flit closes a packet.
   function automatic logic ends_packet(input flit_type_e t);
      return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
   endfunction

endpackage

// File: rtl/rr_priority_4.sv
// rr_priority_4: combinational 4-way round-robin picker.
// Ports:
//   req  [3:0] : request bits, one per port
//   ptr  [1:0] : index of the highest-priority port this cycle
//   gnt  [3:0] : one-hot grant (all zero when no request)
//   idx  [1:0] : index of granted port (equals ptr when no request)
//   any        : at least one request granted
module rr_priority_4
   import noc_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [1:0]           ptr,
   output logic [NUM_PORTS-1:0] gnt,
   output logic [1:0]           idx,
   output logic                 any
);

   logic [1:0] k;

   // Walk upward from ptr, wrapping 3 -> 0; first request wins.
   always_comb begin
      gnt = '0;
      idx = ptr;
      any = 1'b0;
      k   = ptr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         k = ptr + 2'(i);
         if (!any && req[k]) begin
            any    = 1'b1;
            idx    = k;
            gnt[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin, packet-locking (wormhole) arbiter in front
// of one router output port. Picks a packet from one of four inputs, forwards
// its flits head to tail into a single output register, and blocks the other
// inputs until the tail has been accepted.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   inFlitPort1..4 [W-1:0]  : candidate routed flits (port 1 = local)
//   inValid [3:0]           : per-input flit valid
//   inBlock [3:0]           : per-input hold (drives the input's portBlock)
//   outFlit [W-1:0]         : registered output flit
//   outValid                : outFlit valid
//   outBlock                : downstream back-pressure
//   packetCount [15:0]      : packets sent, only with OUTPUT_ARBITER_PKT_COUNT_EN
// Build option: define OUTPUT_ARBITER_PKT_COUNT_EN to add packetCount.
module output_port_arbiter
   import noc_pkg::*;
#(
   parameter int modifiedFlitSize = 34
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [modifiedFlitSize-1:0] inFlitPort1,
   input  logic [modifiedFlitSize-1:0] inFlitPort2,
   input  logic [modifiedFlitSize-1:0] inFlitPort3,
   input  logic [modifiedFlitSize-1:0] inFlitPort4,
   input  logic [NUM_PORTS-1:0]        inValid,
   output logic [NUM_PORTS-1:0]        inBlock,
   output logic [modifiedFlitSize-1:0] outFlit,
   output logic                        outValid,
   input  logic                        outBlock
`ifdef OUTPUT_ARBITER_PKT_COUNT_EN
   ,output logic [15:0]                packetCount
`endif
);

   localparam int W  = modifiedFlitSize;
   localparam int TL = W - FLIT_TYPE_W;

   logic [W-1:0]  in_flit [NUM_PORTS];
   flit_type_e    in_type [NUM_PORTS];

   arb_state_e    state_q,    state_d;
   logic [1:0]    owner_q,    owner_d;
   logic [1:0]    rr_ptr_q,   rr_ptr_d;
   logic [W-1:0]  out_flit_q, out_flit_d;
   logic          out_valid_q, out_valid_d;

   logic [NUM_PORTS-1:0] req, gnt;
   logic [1:0]           win_idx;
   logic                 win_any;
   logic                 can_load, accept;
   logic [W-1:0]         win_flit;
   flit_type_e           win_type;

   assign in_flit[0] = inFlitPort1;
   assign in_flit[1] = inFlitPort2;
   assign in_flit[2] = inFlitPort3;
   assign in_flit[3] = inFlitPort4;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++)
         in_type[p] = flit_type_e'(in_flit[p][W-1:TL]);
   end

   // Requests depend only on valid bits and the type field, never on payload.
   always_comb begin
      req = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (state_q == ARB_IDLE)
            req[p] = inValid[p] && starts_packet(in_type[p]);
         else
            req[p] = inValid[p] && (owner_q == 2'(p));
      end
   end

   // In LOCKED only the owner can request, so the picker simply returns it.
   rr_priority_4 u_pick (
      .req (req),
      .ptr (rr_ptr_q),
      .gnt (gnt),
      .idx (win_idx),
      .any (win_any)
   );

   assign can_load = !out_valid_q || !outBlock;
   assign accept   = can_load && win_any;
   assign win_flit = in_flit[win_idx];
   assign win_type = in_type[win_idx];

   assign inBlock  = reset ? '1 : ~(gnt & {NUM_PORTS{can_load}});
   assign outFlit  = out_flit_q;
   assign outValid = out_valid_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      out_flit_d  = out_flit_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_flit_d  = win_flit;
         out_valid_d = 1'b1;
         if (state_q == ARB_IDLE) begin
            if (win_type == FLIT_HEAD) begin
               state_d = ARB_LOCKED;
               owner_d = win_idx;
            end else begin
               rr_ptr_d = win_idx + 2'd1;
            end
         end else if (win_type == FLIT_TAIL) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = owner_q + 2'd1;
         end
      end else if (can_load) begin
         // Register drained (or empty) with nothing new: go invalid, keep data.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         owner_q     <= 2'd0;
         rr_ptr_q    <= 2'd0;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         out_flit_q  <= out_flit_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef OUTPUT_ARBITER_PKT_COUNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   // Count packets as their last flit leaves the output register.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (out_valid_q && !outBlock && ends_packet(flit_type_e'(out_flit_q[W-1:TL])))
         pkt_cnt_d = pkt_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) pkt_cnt_q <= '0;
      else       pkt_cnt_q <= pkt_cnt_d;
   end

   assign packetCount = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed, table-driven bench for output_port_arbiter.
module tb_output_port_arbiter;

   localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic [33:0] inFlitPort1, inFlitPort2, inFlitPort3, inFlitPort4;
   logic [3:0]  inValid;
   logic [3:0]  inBlock;
   logic [33:0] outFlit;
   logic        outValid;
   logic        outBlock;
`ifdef OUTPUT_ARBITER_PKT_COUNT_EN
   logic [15:0] packetCount;
`endif

   output_port_arbiter #(.modifiedFlitSize(34)) dut (
      .clk         (clk),
      .reset       (reset),
      .inFlitPort1 (inFlitPort1),
      .inFlitPort2 (inFlitPort2),
      .inFlitPort3 (inFlitPort3),
      .inFlitPort4 (inFlitPort4),
      .inValid     (inValid),
      .inBlock     (inBlock),
      .outFlit     (outFlit),
      .outValid    (outValid),
      .outBlock    (outBlock)
`ifdef OUTPUT_ARBITER_PKT_COUNT_EN
      ,.packetCount(packetCount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] vld;
      logic [7:0] ty;    // {port4, port3, port2, port1} types
      logic       ob;
      logic [3:0] blk;   // expected inBlock before the edge
      logic       ov;    // expected outValid after the edge
      int         src;   // port accepted at the edge (1..4), 0 = none
      logic [1:0] rr;    // expected round-robin pointer after the edge
   } vec_t;

   vec_t        vecs[$];
   int          checks = 0;
   int          failures = 0;
   logic [33:0] exp_flit;

   function automatic logic [33:0] mk(input logic [1:0] t, input int n, input int p);
      return {t, n[23:0], p[7:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] vld, input logic [7:0] ty, input logic ob,
                      input logic [3:0] blk, input logic ov, input int src, input logic [1:0] rr);
      vec_t v;
      v.vld = vld; v.ty = ty; v.ob = ob; v.blk = blk; v.ov = ov; v.src = src; v.rr = rr;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [3:0] vld, input logic [7:0] ty, input int n, input logic ob);
      inValid     = vld;
      outBlock    = ob;
      inFlitPort1 = mk(ty[1:0], n, 1);
      inFlitPort2 = mk(ty[3:2], n, 2);
      inFlitPort3 = mk(ty[5:4], n, 3);
      inFlitPort4 = mk(ty[7:6], n, 4);
   endtask

   initial begin
      // single on 2, single on 4, then port 1 packet vs port 3 head
      add(4'b0010, {B,B,S,B}, 0, 4'b1101, 1, 2, 2);
      add(4'b1000, {S,B,B,B}, 0, 4'b0111, 1, 4, 0);
      add(4'b0101, {B,H,B,H}, 0, 4'b1110, 1, 1, 0);
      add(4'b0101, {B,H,B,B}, 0, 4'b1110, 1, 1, 0);
      add(4'b0101, {B,H,B,T}, 0, 4'b1110, 1, 1, 1);
      add(4'b0100, {B,H,B,B}, 0, 4'b1011, 1, 3, 1);
      // 3-cycle downstream stall mid-packet
      add(4'b0100, {B,B,B,B}, 1, 4'b1111, 1, 0, 1);
      add(4'b0100, {B,B,B,B}, 1, 4'b1111, 1, 0, 1);
      add(4'b0100, {B,B,B,B}, 1, 4'b1111, 1, 0, 1);
      add(4'b0100, {B,B,B,B}, 0, 4'b1011, 1, 3, 1);
      add(4'b1101, {H,T,B,H}, 0, 4'b1011, 1, 3, 3);
      add(4'b1001, {H,B,B,H}, 0, 4'b0111, 1, 4, 3);
      add(4'b1001, {T,B,B,H}, 0, 4'b0111, 1, 4, 0);
      add(4'b1001, {B,B,B,S}, 0, 4'b1110, 1, 1, 1);
      // body / tail in IDLE never accepted
      add(4'b1000, {B,B,B,B}, 0, 4'b1111, 0, 0, 1);
      add(4'b1000, {B,B,B,B}, 1, 4'b1111, 0, 0, 1);
      add(4'b1000, {T,B,B,B}, 0, 4'b1111, 0, 0, 1);
      add(4'b1000, {S,B,B,B}, 0, 4'b0111, 1, 4, 0);
      // all four ports streaming 2-flit packets
      add(4'b1111, {H,H,H,H}, 0, 4'b1110, 1, 1, 0);
      add(4'b1111, {H,H,H,T}, 0, 4'b1110, 1, 1, 1);
      add(4'b1111, {H,H,H,H}, 0, 4'b1101, 1, 2, 1);
      add(4'b1111, {H,H,T,H}, 0, 4'b1101, 1, 2, 2);
      add(4'b1111, {H,H,H,H}, 0, 4'b1011, 1, 3, 2);
      add(4'b1111, {H,T,H,H}, 0, 4'b1011, 1, 3, 3);
      add(4'b1111, {H,H,H,H}, 0, 4'b0111, 1, 4, 3);
      add(4'b1111, {T,H,H,H}, 0, 4'b0111, 1, 4, 0);
      add(4'b1111, {H,H,H,H}, 0, 4'b1110, 1, 1, 0);
      add(4'b1111, {H,H,H,T}, 0, 4'b1110, 1, 1, 1);
      add(4'b0000, {B,B,B,B}, 0, 4'b1111, 0, 0, 1);

      // reset
      reset = 1'b1;
      drive(4'b1111, {H,H,H,H}, 0, 1'b0);
      @(negedge clk);
      check("reset_inblock", 64'(inBlock), 64'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset_outvalid", 64'(outValid), 64'd0);
      check("reset_outflit", 64'(outFlit), 64'd0);
      check("reset_state", 64'(dut.state_q), 64'd0);
      check("reset_rrptr", 64'(dut.rr_ptr_q), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(4'b0000, {B,B,B,B}, 0, 1'b0);
      exp_flit = '0;

      for (int n = 0; n < vecs.size(); n++) begin
         logic [7:0] tyv;
         @(negedge clk);
         drive(vecs[n].vld, vecs[n].ty, n, vecs[n].ob);
         #1;
         check($sformatf("v%0d_inblock", n), 64'(inBlock), 64'(vecs[n].blk));
         tyv = vecs[n].ty;
         if (vecs[n].src != 0)
            exp_flit = mk(2'(tyv >> (2 * (vecs[n].src - 1))), n, vecs[n].src);
         @(posedge clk); #1;
         check($sformatf("v%0d_outvalid", n), 64'(outValid), 64'(vecs[n].ov));
         check($sformatf("v%0d_outflit", n), 64'(outFlit), 64'(exp_flit));
         check($sformatf("v%0d_rrptr", n), 64'(dut.rr_ptr_q), 64'(vecs[n].rr));
      end

      // reset while LOCKED with a valid registered flit
      @(negedge clk);
      drive(4'b0010, {B,B,H,B}, 100, 1'b0);
      #1 check("lock_inblock", 64'(inBlock), 64'hD);
      @(posedge clk); #1;
      check("lock_state", 64'(dut.state_q), 64'd1);
      check("lock_outvalid", 64'(outValid), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      drive(4'b0010, {B,B,B,B}, 101, 1'b0);
      #1 check("rst_lock_inblock", 64'(inBlock), 64'hF);
      @(posedge clk); #1;
      check("rst_lock_outvalid", 64'(outValid), 64'd0);
      check("rst_lock_state", 64'(dut.state_q), 64'd0);
      check("rst_lock_outflit", 64'(outFlit), 64'd0);
`ifdef OUTPUT_ARBITER_PKT_COUNT_EN
      check("rst_pktcount", 64'(packetCount), 64'd0);
`endif

      // two single flits after reset
      @(negedge clk);
      reset = 1'b0;
      drive(4'b0001, {B,B,B,S}, 102, 1'b0);
      @(posedge clk); #1;
      check("s1_outflit", 64'(outFlit), 64'(mk(S, 102, 1)));
      @(negedge clk);
      drive(4'b0010, {B,B,S,B}, 103, 1'b0);
      @(posedge clk); #1;
      check("s2_outflit", 64'(outFlit), 64'(mk(S, 103, 2)));
      @(negedge clk);
      drive(4'b0000, {B,B,B,B}, 104, 1'b0);
      @(posedge clk); #1;
      check("s_drain_outvalid", 64'(outValid), 64'd0);
`ifdef OUTPUT_ARBITER_PKT_COUNT_EN
      check("pktcount_two", 64'(packetCount), 64'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
